// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback request bus and register-file write port.
// master modport = the functional-unit side (drives requests),
// slave modport  = the arbiter side (drives ready, write port and wakeup).
interface wb_port_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_PHYS_REGS = 64
);
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int GW       = $clog2(NUM_REQ);

    // Handshake: a result transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready depends only on registered state.
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*LOG_PHYS-1:0] req_preg;
    logic [NUM_REQ*32-1:0]       req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        Write1;
    logic [LOG_PHYS-1:0]         WriteReg1;
    logic [31:0]                 WriteData1;
    logic                        wake_valid;
    logic [LOG_PHYS-1:0]         wake_preg;
    logic [GW-1:0]               grant_id;

    modport master (
        output req_valid, req_preg, req_data,
        input  req_ready, Write1, WriteReg1, WriteData1, wake_valid, wake_preg, grant_id
    );

    modport slave (
        input  req_valid, req_preg, req_data,
        output req_ready, Write1, WriteReg1, WriteData1, wake_valid, wake_preg, grant_id
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port among NUM_REQ
// writeback sources. Each source has a QDEPTH-entry FIFO; one head is granted
// per cycle and registered onto Write1/WriteReg1/WriteData1 and the wakeup bus.
// Optional macro WB_ROUND_ROBIN_EN: rotating priority starting at rr_ptr;
// otherwise fixed lowest-index priority.
module wb_port_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_PHYS_REGS = 64,
    parameter int QDEPTH        = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  flush,
    wb_port_arbiter_if.slave      bus
);
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int GW       = $clog2(NUM_REQ);
    localparam int PW       = $clog2(QDEPTH);
    localparam int CW       = PW + 1;

    logic [CW-1:0]       count  [NUM_REQ];
    logic [PW-1:0]       rd_ptr [NUM_REQ];
    logic [PW-1:0]       wr_ptr [NUM_REQ];
    logic [LOG_PHYS-1:0] q_preg [NUM_REQ][QDEPTH];
    logic [31:0]         q_data [NUM_REQ][QDEPTH];

    logic [NUM_REQ-1:0]  ready;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  push;
    logic [NUM_REQ-1:0]  pop;
    logic                grant_valid;
    logic [GW-1:0]       grant_idx;

    logic                write_en;
    logic [LOG_PHYS-1:0] write_reg;
    logic [31:0]         write_data;
    logic [GW-1:0]       grant_q;

    // Queue status, push/pop qualification; ready comes from registered count only.
    always_comb begin
        ready    = '0;
        eligible = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i]    = (count[i] < CW'(QDEPTH));
            eligible[i] = (count[i] != '0);
            push[i]     = bus.req_valid[i] && ready[i] && !flush;
            pop[i]      = grant_valid && !flush && (grant_idx == GW'(i));
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    logic [GW-1:0] rr_ptr;

    // Rotating priority: search starts at rr_ptr and wraps.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    // Advance the pointer past the source just served; hold on idle or flush.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_ptr <= '0;
        end else if (grant_valid && !flush) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + GW'(1);
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && eligible[k]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(k);
            end
        end
    end
`endif

    // Queue bookkeeping: counts and pointers; flush clears everything.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
            end
        end
    end

    // Queue storage: written on push, contents need no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                q_preg[i][wr_ptr[i]] <= bus.req_preg[i*LOG_PHYS +: LOG_PHYS];
                q_data[i][wr_ptr[i]] <= bus.req_data[i*32 +: 32];
            end
        end
    end

    // Output register: load the granted head; payload holds when idle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_q    <= '0;
        end else begin
            write_en <= grant_valid && !flush;
            if (grant_valid && !flush) begin
                write_reg  <= q_preg[grant_idx][rd_ptr[grant_idx]];
                write_data <= q_data[grant_idx][rd_ptr[grant_idx]];
                grant_q    <= grant_idx;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.Write1     = write_en;
    assign bus.WriteReg1  = write_reg;
    assign bus.WriteData1 = write_data;
    assign bus.wake_valid = write_en;
    assign bus.wake_preg  = write_reg;
    assign bus.grant_id   = grant_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random writeback traffic; a queue-level
// reference model predicts each register-file write and its cycle, and a
// monitor compares every write (and every idle cycle) against the prediction.
module tb_wb_port_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int NUM_PHYS_REGS = 64;
    localparam int QDEPTH        = 2;
    localparam int LOG_PHYS      = 6;

    logic clk;
    logic RESET;
    logic flush;

    wb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_PHYS_REGS(NUM_PHYS_REGS)) bus();

    wb_port_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_PHYS_REGS(NUM_PHYS_REGS), .QDEPTH(QDEPTH)
    ) dut (
        .CLK(clk), .RESET(RESET), .flush(flush), .bus(bus)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: {cycle[15:0], gid[2:0], preg[5:0], data[31:0]}
    logic [56:0] exp_q[$];
    logic [37:0] mq[NUM_REQ][$];
    int          rr = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [NUM_REQ-1:0]          sv;
    logic [NUM_REQ*LOG_PHYS-1:0] sp;
    logic [NUM_REQ*32-1:0]       sd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_in();
        sv = '0;
        sp = '0;
        sd = '0;
    endtask

    task automatic set_src(input int i, input logic [5:0] p, input logic [31:0] d);
        sv[i]             = 1'b1;
        sp[i*LOG_PHYS +: LOG_PHYS] = p;
        sd[i*32 +: 32]    = d;
    endtask

    // Driver + reference model: one clock cycle of stimulus.
    task automatic step(input logic fl);
        logic [NUM_REQ-1:0] rdy;
        logic [37:0]        h;
        int                 g;
        int                 idx;
        int                 start;
        @(negedge clk);
        bus.req_valid = sv;
        bus.req_preg  = sp;
        bus.req_data  = sd;
        flush         = fl;
        for (int i = 0; i < NUM_REQ; i++) rdy[i] = (mq[i].size() < QDEPTH);
        check("req_ready", 64'(bus.req_ready), 64'(rdy));
        start = 0;
`ifdef WB_ROUND_ROBIN_EN
        start = rr;
`endif
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (start + k) % NUM_REQ;
            if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        if (fl) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
        end else begin
            if (g >= 0) begin
                h = mq[g].pop_front();
                exp_q.push_back({16'(cyc + 1), 3'(g), h});
                rr = (g + 1) % NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (sv[i] && rdy[i]) mq[i].push_back({sp[i*LOG_PHYS +: LOG_PHYS], sd[i*32 +: 32]});
        end
    endtask

    task automatic idle(input int n);
        clr_in();
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    // Monitor: compares each cycle's write port against the oldest prediction.
    initial begin
        logic [56:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!RESET) begin
                if (bus.Write1) begin
                    check("wake_valid", 64'(bus.wake_valid), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got preg %0d data %0h expected no write (cycle %0d)",
                                 bus.WriteReg1, bus.WriteData1, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_cycle", 64'(cyc), 64'(e[56:41]));
                        check("grant_id", 64'(bus.grant_id), 64'(e[40:38]));
                        check("WriteReg1", 64'(bus.WriteReg1), 64'(e[37:32]));
                        check("WriteData1", 64'(bus.WriteData1), 64'(e[31:0]));
                        check("wake_preg", 64'(bus.wake_preg), 64'(e[37:32]));
                    end
                end else begin
                    check("wake_valid_idle", 64'(bus.wake_valid), 64'd0);
                    if (exp_q.size() != 0 && int'(exp_q[0][56:41]) <= cyc) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        n_err++;
                        $display("FAIL missing_write: got Write1=0 expected preg %0d data %0h (cycle %0d)",
                                 e[37:32], e[31:0], cyc);
                    end
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        RESET = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_preg  = '0;
        bus.req_data  = '0;
        clr_in();
        repeat (2) @(negedge clk);
        check("rst_Write1", 64'(bus.Write1), 64'd0);
        check("rst_WriteReg1", 64'(bus.WriteReg1), 64'd0);
        check("rst_WriteData1", 64'(bus.WriteData1), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        check("rst_wake_preg", 64'(bus.wake_preg), 64'd0);
        RESET = 1'b0;

        // Single write from source 2
        idle(3);
        clr_in();
        set_src(2, 6'd5, 32'hDEADBEEF);
        step(1'b0);
        idle(4);

        // Contention: all four sources at once
        clr_in();
        for (int i = 0; i < NUM_REQ; i++) set_src(i, 6'(10 + i), 32'h1000 + 32'(i));
        step(1'b0);
        idle(6);

        // Back-pressure: sources 0 and 1 push every cycle
        for (int k = 0; k < 8; k++) begin
            clr_in();
            set_src(0, 6'(30 + k), 32'hA000 + 32'(k));
            set_src(1, 6'(40 + k), 32'hB000 + 32'(k));
            step(1'b0);
        end
        idle(12);

        // Simultaneous push and pop on source 3
        clr_in();
        set_src(3, 6'd19, 32'h19);
        step(1'b0);
        clr_in();
        set_src(3, 6'd20, 32'h20);
        step(1'b0);
        idle(4);

        // Flush with three queued entries and a push in the flush cycle
        clr_in();
        for (int i = 0; i < 3; i++) set_src(i, 6'(50 + i), 32'hF000 + 32'(i));
        step(1'b0);
        clr_in();
        set_src(3, 6'd55, 32'hF555);
        step(1'b1);
        idle(4);

        // Random traffic with occasional flushes
        for (int k = 0; k < 300; k++) begin
            clr_in();
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 99) < 45) set_src(i, 6'($urandom_range(0, 63)), $urandom);
            step($urandom_range(0, 24) == 0);
        end
        idle(10);

        // Asynchronous reset while a write is in the output register
        clr_in();
        for (int i = 0; i < NUM_REQ; i++) set_src(i, 6'(60 + i), 32'hC000 + 32'(i));
        step(1'b0);
        idle(1);
        @(posedge clk);
        #2;
        check("pre_reset_Write1", 64'(bus.Write1), 64'd1);
        RESET = 1'b1;
        #1;
        check("async_Write1", 64'(bus.Write1), 64'd0);
        check("async_WriteReg1", 64'(bus.WriteReg1), 64'd0);
        check("async_WriteData1", 64'(bus.WriteData1), 64'd0);
        check("async_wake_valid", 64'(bus.wake_valid), 64'd0);
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
        rr = 0;
        #1;
        RESET = 1'b0;
        idle(5);
        clr_in();
        set_src(1, 6'd0, 32'h0BAD_F00D);
        step(1'b0);
        idle(5);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single physical-register-file write port (Write1/WriteReg1/WriteData1) among NUM_REQ writeback sources (ALU0, ALU1, MEM, MULDIV).
- Each source has a 2-entry input queue. One queue head is granted per cycle and registered onto the write port.
- The same registered result is broadcast as a wakeup tag to the issue queues.
- Sits between the functional-unit result buses and the physical register file.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- NUM_PHYS_REGS, 64, physical register count; LOG_PHYS = $clog2(NUM_PHYS_REGS).
- QDEPTH, 2, entries per input queue (power of two, ≥2).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline squash; empties all queues.
- req_valid  in  NUM_REQ  per-source result valid.
- req_preg  in  NUM_REQ*LOG_PHYS  per-source destination physical reg; source i occupies bits [i*LOG_PHYS +: LOG_PHYS].
- req_data  in  NUM_REQ*32  per-source result; source i occupies [i*32 +: 32].
- req_ready  out  NUM_REQ  per-source queue can accept.
- Write1  out  1  register-file write enable.
- WriteReg1  out  LOG_PHYS  register-file write index.
- WriteData1  out  32  register-file write data.
- wake_valid  out  1  wakeup broadcast valid; equals Write1.
- wake_preg  out  LOG_PHYS  wakeup tag; equals WriteReg1.
- grant_id  out  $clog2(NUM_REQ)  source index of the current write (debug).

Behaviour:
- Reset (async, RESET=1):
  - All queue counts, read pointers and write pointers = 0.
  - Write1, WriteReg1, WriteData1, wake_valid, wake_preg, grant_id = 0.
  - req_ready = all ones once RESET deasserts.
  - Assertion mid-operation discards all queued and in-flight results immediately.
- Queues:
  - req_ready[i] = (count[i] < QDEPTH). Registered-state function only; no combinational path from req_valid or the grant.
  - Push on a rising edge when req_valid[i] && req_ready[i].
  - Pop of source i when granted.
  - Push and pop in the same cycle: count unchanged; data ordering preserved (FIFO).
  - A full queue whose head is popped does not accept a push in that cycle, because ready was already low.
  - Pointers wrap modulo QDEPTH.
- Arbitration (combinational over the queue heads):
  - Eligible set = {i : count[i] != 0}.
  - Default is fixed priority: lowest index wins.
  - Exactly one grant per cycle when the eligible set is non-empty.
- Output register (updated every edge):
  - Write1 <= any eligible && !flush.
  - WriteReg1, WriteData1 and grant_id are loaded from the granted head.
  - When nothing is granted, Write1 = 0 and the other outputs hold their values.
- Latency: a request presented in cycle c, with its queue empty and no competing heads, produces Write1=1 in cycle c+2. Throughput is 1 write per cycle.
- Flush:
  - At the edge where flush=1, all counts and pointers clear, no pop is recorded, and Write1 <= 0.
  - Pushes presented in the flush cycle are dropped.
  - A write already in the output register during the flush cycle still completes; it was issued before the squash.
- Preg 0: no special treatment. Written like any other index.

Optional Feature:
- Macro WB_ROUND_ROBIN_EN.
- Defined:
  - A registered pointer rr_ptr (reset 0) gives search priority starting at index rr_ptr, wrapping.
  - After a grant to source g, rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant or on flush.
  - Guarantees that a continuously non-empty queue is served within NUM_REQ cycles.
- Undefined: fixed lowest-index priority; no rr_ptr register exists.

Test Plan:
- Single write: after reset, source 2 sends preg=5, data=0xDEADBEEF in cycle 3 → Write1=1, WriteReg1=5, WriteData1=0xDEADBEEF, grant_id=2, wake_preg=5 in cycle 5 only.
- Contention, fixed priority: sources 0..3 all push one result in the same cycle (pregs 10,11,12,13) → writes to 10,11,12,13 on four consecutive cycles. With WB_ROUND_ROBIN_EN and rr_ptr=2 at grant time, the order is 12,13,10,11.
- Back-pressure: source 1 pushes every cycle while source 0 is continuously non-empty (fixed priority) → req_ready[1] drops to 0 after 2 accepted pushes. No data is lost; source 1 order is preserved once source 0 drains.
- Simultaneous push and pop: source 3 has count=1 and pushes preg 20 in the cycle its head (preg 19) is granted → count stays 1; 19 is written, then 20 on the next cycle.
- Flush: queues hold 3 entries and flush=1 in cycle k → Write1=0 in cycle k+1, all req_ready=1, and no queued preg is ever written. A result pushed in cycle k is dropped.
- Async reset mid-stream: RESET is pulsed between clock edges while Write1=1 → Write1, WriteReg1 and WriteData1 go to 0 immediately. There is no output activity until new pushes arrive.
